// File: rtl/select_encode_seq_if.sv
// Control-unit side bundle of the register select/encode unit: instruction,
// manual selects and strobes, sequencer handshake and the enable vectors.
interface select_encode_seq_if #(
   parameter int REG_COUNT = 16,
   parameter int SEL_W     = 4,
   parameter int DATA_W    = 32
);
   logic [DATA_W-1:0]    IR_in;
   logic                 IR_load;
   logic                 G_ra;
   logic                 G_rb;
   logic                 G_rc;
   logic                 R_in;
   logic                 R_out;
   logic                 BA_out;
   logic                 seq_start;
   logic                 seq_ba;
   logic                 seq_ready;
   logic                 seq_done;
   logic [REG_COUNT-1:0] write_signals;
   logic [REG_COUNT-1:0] read_signals;
   logic [DATA_W-1:0]    C_sign_extended;
   logic                 sel_conflict;

   modport master (
      output IR_in, IR_load, G_ra, G_rb, G_rc, R_in, R_out, BA_out, seq_start, seq_ba,
      input  seq_ready, seq_done, write_signals, read_signals, C_sign_extended, sel_conflict
   );

   modport slave (
      input  IR_in, IR_load, G_ra, G_rb, G_rc, R_in, R_out, BA_out, seq_start, seq_ba,
      output seq_ready, seq_done, write_signals, read_signals, C_sign_extended, sel_conflict
   );
endinterface

// File: rtl/select_encode_seq.sv
// Register select/encode unit: IR latch, registered one-hot Rin/Rout enables,
// constant sign extension and a read-Rb / read-Rc / write-Ra operand sequencer.
module select_encode_seq #(
   parameter int REG_COUNT = 16,
   parameter int SEL_W     = 4,
   parameter int DATA_W    = 32,
   parameter int RA_LSB    = 23,
   parameter int RB_LSB    = 19,
   parameter int RC_LSB    = 15,
   parameter int C_W       = 19
) (
   input logic                clock,
   input logic                reset,
   select_encode_seq_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SRC_B = 2'd1;
   localparam logic [1:0] SRC_C = 2'd2;
   localparam logic [1:0] DST_A = 2'd3;

   function automatic logic [REG_COUNT-1:0] onehot(input logic [SEL_W-1:0] sel_f);
      onehot = REG_COUNT'(1) << sel_f;
   endfunction

   function automatic logic signed [DATA_W-1:0] sign_ext(input logic [DATA_W-1:0] word);
      sign_ext = {{(DATA_W-C_W){word[C_W-1]}}, word[C_W-1:0]};
   endfunction

   logic [1:0]           state;
   logic [1:0]           state_d;
   logic [DATA_W-1:0]    ir_p0;
   logic [DATA_W-1:0]    ir_d;
   logic [REG_COUNT-1:0] read_p1;
   logic [REG_COUNT-1:0] write_p1;
   logic [REG_COUNT-1:0] read_d;
   logic [REG_COUNT-1:0] write_d;
   logic                 done_p1;
   logic                 done_d;
   logic                 conflict_p1;
   logic                 conflict_d;
   logic                 idle;
   logic [SEL_W-1:0]     ra;
   logic [SEL_W-1:0]     rb;
   logic [SEL_W-1:0]     rc;
   logic [SEL_W-1:0]     sel;
   logic                 any_g;
   logic                 multi_g;
   logic                 ir_unused;

   assign idle = (state == IDLE);
   assign ir_d = (idle && bus.IR_load) ? bus.IR_in : ir_p0;

   // Fields are taken from the IR register's next value, so a load that
   // coincides with seq_start feeds the new instruction into the sequence.
   assign ra = ir_d[RA_LSB +: SEL_W];
   assign rb = ir_d[RB_LSB +: SEL_W];
   assign rc = ir_d[RC_LSB +: SEL_W];
   assign ir_unused = ^ir_d;

   assign any_g   = bus.G_ra | bus.G_rb | bus.G_rc;
   assign multi_g = (bus.G_ra & bus.G_rb) | (bus.G_ra & bus.G_rc) | (bus.G_rb & bus.G_rc);
   assign sel     = bus.G_ra ? ra : (bus.G_rb ? rb : rc);

   // Next-cycle enables are decoded for the state being entered.
   always_comb begin
      state_d    = state;
      read_d     = '0;
      write_d    = '0;
      done_d     = 1'b0;
      conflict_d = conflict_p1;
      case (state)
         IDLE: begin
            if (bus.seq_start) begin
               state_d = SRC_B;
               if (!(bus.seq_ba && rb == '0)) read_d = onehot(rb);
            end else begin
               if (multi_g) conflict_d = 1'b1;
               if (any_g && bus.R_in) write_d = onehot(sel);
               if (any_g && (bus.R_out || (bus.BA_out && sel != '0))) read_d = onehot(sel);
            end
         end
         SRC_B: begin
            state_d = SRC_C;
            read_d  = onehot(rc);
         end
         SRC_C: begin
            state_d = DST_A;
            write_d = onehot(ra);
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage p1: registered state, IR and enable outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ir_p0       <= '0;
         read_p1     <= '0;
         write_p1    <= '0;
         done_p1     <= 1'b0;
         conflict_p1 <= 1'b0;
      end else begin
         state       <= state_d;
         ir_p0       <= ir_d;
         read_p1     <= read_d;
         write_p1    <= write_d;
         done_p1     <= done_d;
         conflict_p1 <= conflict_d;
      end
   end

   assign bus.seq_ready       = idle;
   assign bus.seq_done        = done_p1;
   assign bus.read_signals    = read_p1;
   assign bus.write_signals   = write_p1;
   assign bus.sel_conflict    = conflict_p1;
   assign bus.C_sign_extended = sign_ext(ir_p0);

endmodule

// File: tb/tb_select_encode_seq.sv
// Scoreboard bench for select_encode_seq: each scenario queues expected
// outputs as it drives a cycle and pops them once the DUT has clocked.
module tb_select_encode_seq;

   typedef struct packed {
      logic        ld;
      logic [31:0] ir;
      logic        ga, gb, gc, rin, rout, ba, ss, sba;
   } stim_t;

   typedef struct packed {
      logic [15:0] rd;
      logic [15:0] wr;
      logic        done;
      logic        ready;
      logic        conflict;
   } obs_t;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   obs_t exp_q[$];

   select_encode_seq_if #(.REG_COUNT(16), .SEL_W(4), .DATA_W(32)) bus ();

   select_encode_seq dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic stim_t mk(input logic ld, input logic [31:0] ir,
                                input logic ga, input logic gb, input logic gc,
                                input logic rin, input logic rout, input logic ba,
                                input logic ss, input logic sba);
      mk = {ld, ir, ga, gb, gc, rin, rout, ba, ss, sba};
   endfunction

   function automatic stim_t s_idle();
      s_idle = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic stim_t s_load(input logic [31:0] ir);
      s_load = mk(1'b1, ir, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endfunction

   function automatic stim_t s_man(input logic ga, input logic gb, input logic gc,
                                   input logic rin, input logic rout, input logic ba);
      s_man = mk(1'b0, 32'h0, ga, gb, gc, rin, rout, ba, 1'b0, 1'b0);
   endfunction

   function automatic stim_t s_seq(input logic sba);
      s_seq = mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sba);
   endfunction

   function automatic obs_t o(input logic [15:0] rd, input logic [15:0] wr,
                              input logic done, input logic ready, input logic conflict);
      o = {rd, wr, done, ready, conflict};
   endfunction

   function automatic obs_t observe();
      observe = {bus.read_signals, bus.write_signals, bus.seq_done, bus.seq_ready, bus.sel_conflict};
   endfunction

   task automatic apply(input stim_t s);
      bus.IR_load   = s.ld;
      bus.IR_in     = s.ir;
      bus.G_ra      = s.ga;
      bus.G_rb      = s.gb;
      bus.G_rc      = s.gc;
      bus.R_in      = s.rin;
      bus.R_out     = s.rout;
      bus.BA_out    = s.ba;
      bus.seq_start = s.ss;
      bus.seq_ba    = s.sba;
   endtask

   task automatic test_reset();
      obs_t got, want;
      apply(s_idle());
      reset = 1'b1;
      exp_q.push_back(o(16'h0, 16'h0, 1'b0, 1'b1, 1'b0));
      repeat (2) @(posedge clock);
      #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL reset_outputs got %h want %h", got, want);
      end
      checks++;
      if (bus.C_sign_extended !== 32'h0) begin
         errors++;
         $display("FAIL reset_C got %h want %h", bus.C_sign_extended, 32'h0);
      end
      apply(mk(1'b1, 32'h029B8000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(o(16'h0, 16'h0, 1'b0, 1'b1, 1'b0));
      @(posedge clock); #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL reset_holds got %h want %h", got, want);
      end
      apply(s_idle());
      reset = 1'b0;
   endtask

   task automatic test_sequence();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(s_load(32'h029B8000)); ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_seq(1'b0));          ex.push_back(o(16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0));
      st.push_back(s_idle());             ex.push_back(o(16'h0080, 16'h0000, 1'b0, 1'b0, 1'b0));
      st.push_back(s_idle());             ex.push_back(o(16'h0000, 16'h0020, 1'b1, 1'b0, 1'b0));
      st.push_back(s_idle());             ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      foreach (st[i]) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL sequence[%0d] got rd=%h wr=%h done=%b ready=%b conflict=%b want rd=%h wr=%h done=%b ready=%b conflict=%b",
                     i, got.rd, got.wr, got.done, got.ready, got.conflict,
                     want.rd, want.wr, want.done, want.ready, want.conflict);
         end
      end
      checks++;
      if (bus.C_sign_extended !== 32'h00038000) begin
         errors++;
         $display("FAIL sequence_C got %h want %h", bus.C_sign_extended, 32'h00038000);
      end
   endtask

   task automatic test_sign_ext();
      logic [31:0] irs[3];
      logic [31:0] cs[3];
      obs_t        got, want;
      irs[0] = 32'h0007FFFF; cs[0] = 32'hFFFFFFFF;
      irs[1] = 32'h00040000; cs[1] = 32'hFFFC0000;
      irs[2] = 32'h0003FFFF; cs[2] = 32'h0003FFFF;
      for (int i = 0; i < 3; i++) begin
         apply(s_load(irs[i]));
         exp_q.push_back(o(16'h0, 16'h0, 1'b0, 1'b1, 1'b0));
         @(posedge clock); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL sign_ext_idle[%0d] got %h want %h", i, got, want);
         end
         checks++;
         if (bus.C_sign_extended !== cs[i]) begin
            errors++;
            $display("FAIL sign_ext[%0d] got %h want %h", i, bus.C_sign_extended, cs[i]);
         end
      end
      apply(s_idle());
   endtask

   task automatic test_base_addr();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      // Ra=2 Rb=0 Rc=4, then Ra=9 Rb=0 Rc=6 loaded together with seq_start
      st.push_back(s_load(32'h01020000));                   ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_man(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)); ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_man(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); ex.push_back(o(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_man(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1)); ex.push_back(o(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_man(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); ex.push_back(o(16'h0004, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(mk(1'b1, 32'h04830000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
                                                            ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0));
      st.push_back(s_idle());                               ex.push_back(o(16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0));
      st.push_back(s_idle());                               ex.push_back(o(16'h0000, 16'h0200, 1'b1, 1'b0, 1'b0));
      st.push_back(s_idle());                               ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_seq(1'b0));                            ex.push_back(o(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0));
      st.push_back(s_idle());                               ex.push_back(o(16'h0040, 16'h0000, 1'b0, 1'b0, 1'b0));
      st.push_back(s_idle());                               ex.push_back(o(16'h0000, 16'h0200, 1'b1, 1'b0, 1'b0));
      st.push_back(s_idle());                               ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      foreach (st[i]) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL base_addr[%0d] got rd=%h wr=%h done=%b ready=%b conflict=%b want rd=%h wr=%h done=%b ready=%b conflict=%b",
                     i, got.rd, got.wr, got.done, got.ready, got.conflict,
                     want.rd, want.wr, want.done, want.ready, want.conflict);
         end
      end
   endtask

   task automatic test_dual_strobe();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(s_load(32'h029B8000));                   ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_man(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_man(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0)); ex.push_back(o(16'h0008, 16'h0008, 1'b0, 1'b1, 1'b0));
      st.push_back(s_idle());                               ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      foreach (st[i]) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL dual_strobe[%0d] got rd=%h wr=%h want rd=%h wr=%h (done/ready/conflict %b%b%b vs %b%b%b)",
                     i, got.rd, got.wr, want.rd, want.wr, got.done, got.ready, got.conflict,
                     want.done, want.ready, want.conflict);
         end
      end
   endtask

   task automatic test_priority_conflict();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(s_load(32'h029B8000));                   ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_man(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)); ex.push_back(o(16'h0000, 16'h0020, 1'b0, 1'b1, 1'b1));
      st.push_back(s_idle());                               ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1));
      st.push_back(s_idle());                               ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1));
      st.push_back(s_man(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)); ex.push_back(o(16'h0000, 16'h0080, 1'b0, 1'b1, 1'b1));
      st.push_back(s_man(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0)); ex.push_back(o(16'h0008, 16'h0000, 1'b0, 1'b1, 1'b1));
      foreach (st[i]) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL priority[%0d] got rd=%h wr=%h conflict=%b want rd=%h wr=%h conflict=%b (done/ready %b%b vs %b%b)",
                     i, got.rd, got.wr, got.conflict, want.rd, want.wr, want.conflict,
                     got.done, got.ready, want.done, want.ready);
         end
      end
      apply(s_idle());
      reset = 1'b1;
      exp_q.push_back(o(16'h0, 16'h0, 1'b0, 1'b1, 1'b0));
      #2;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL conflict_cleared got %h want %h", got, want);
      end
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_busy_rules();
      stim_t st[$];
      obs_t  ex[$];
      obs_t  got, want;
      st.push_back(s_load(32'h029B8000)); ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_seq(1'b0));          ex.push_back(o(16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0));
      st.push_back(s_idle());             ex.push_back(o(16'h0080, 16'h0000, 1'b0, 1'b0, 1'b0));
      st.push_back(mk(1'b1, 32'h00040000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
                                          ex.push_back(o(16'h0000, 16'h0020, 1'b1, 1'b0, 1'b0));
      st.push_back(s_idle());             ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_idle());             ex.push_back(o(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0));
      st.push_back(s_seq(1'b0));          ex.push_back(o(16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0));
      st.push_back(s_idle());             ex.push_back(o(16'h0080, 16'h0000, 1'b0, 1'b0, 1'b0));
      foreach (st[i]) begin
         apply(st[i]);
         exp_q.push_back(ex[i]);
         @(posedge clock); #1;
         got = observe(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL busy[%0d] got rd=%h wr=%h done=%b ready=%b conflict=%b want rd=%h wr=%h done=%b ready=%b conflict=%b",
                     i, got.rd, got.wr, got.done, got.ready, got.conflict,
                     want.rd, want.wr, want.done, want.ready, want.conflict);
         end
         if (i == 5) begin
            checks++;
            if (bus.C_sign_extended !== 32'h00038000) begin
               errors++;
               $display("FAIL busy_ir_kept got %h want %h", bus.C_sign_extended, 32'h00038000);
            end
         end
      end
      // Now in SRC_C: reset must clear everything without waiting for an edge
      reset = 1'b1;
      exp_q.push_back(o(16'h0, 16'h0, 1'b0, 1'b1, 1'b0));
      #2;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL mid_seq_reset got %h want %h", got, want);
      end
      checks++;
      if (bus.C_sign_extended !== 32'h0) begin
         errors++;
         $display("FAIL mid_seq_reset_C got %h want %h", bus.C_sign_extended, 32'h0);
      end
      @(posedge clock); #1;
      reset = 1'b0;
      exp_q.push_back(o(16'h0, 16'h0, 1'b0, 1'b1, 1'b0));
      @(posedge clock); #1;
      got = observe(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL after_reset_no_done got %h want %h", got, want);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      apply(s_idle());
      test_reset();
      test_sequence();
      test_sign_ext();
      test_base_addr();
      test_dual_strobe();
      test_priority_conflict();
      test_busy_rules();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
